// File: rtl/mem_access_unit.sv
// mem_access_unit: RISC-V load/store initiator with sign/zero-extension and byte/half read-modify-write.
// Optional `MISALIGN_TRAP_EN turns misaligned H/HU/SH and W/SW requests into error responses.
module mem_access_unit #(
    parameter logic [31:0] START_ADDR = 32'h01000000,
    parameter logic [31:0] MEM_BYTES  = 32'd1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_w_enable,
    input  logic [31:0] mem_data_out
);
    typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, RESP} state_t;
    localparam logic [31:0] LAST_ADDR = START_ADDR + MEM_BYTES - 32'd4;
    state_t      state;
    logic        wr_q;
    logic [2:0]  f3_q;
    logic [31:0] wdata_q, old_q, load_ext;
    logic        bad_f3, bad_range, bad_align, req_err;
    assign bad_f3 = (req_funct3[1:0] == 2'b11) || (req_funct3[2] && (req_write || req_funct3[1]));
    assign bad_range = (req_addr < START_ADDR) || (req_addr > LAST_ADDR);
`ifdef MISALIGN_TRAP_EN
    assign bad_align = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                       (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign bad_align = 1'b0;
`endif
    assign req_err = bad_f3 | bad_range | bad_align;
    assign load_ext = f3_q[1] ? mem_data_out :
                      f3_q[0] ? {{16{~f3_q[2] & mem_data_out[15]}}, mem_data_out[15:0]} :
                                {{24{~f3_q[2] & mem_data_out[7]}}, mem_data_out[7:0]};
    assign req_ready    = rst_n && state == IDLE;
    assign resp_valid   = rst_n && state == RESP;
    // Write strobe is gated by reset so an in-flight store is dropped at the reset edge
    assign mem_w_enable = rst_n && ((state == ACCESS && wr_q) || state == RMW_WR);
    assign mem_data_in  = !rst_n ? '0 :
                          state == RMW_WR ? (f3_q[0] ? {old_q[31:16], wdata_q[15:0]} : {old_q[31:8], wdata_q[7:0]}) :
                          wdata_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            old_q       <= '0;
            mem_address <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    wr_q    <= req_write;
                    f3_q    <= req_funct3;
                    wdata_q <= req_wdata;
                    if (req_err) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        state      <= RESP;
                    end else begin
                        mem_address <= req_addr;
                        state       <= (req_write && !req_funct3[1]) ? RMW_RD : ACCESS;
                    end
                end
                ACCESS: begin
                    resp_rdata <= wr_q ? '0 : load_ext;
                    resp_err   <= 1'b0;
                    state      <= RESP;
                end
                RMW_RD: begin
                    old_q <= mem_data_out;
                    state <= RMW_WR;
                end
                RMW_WR: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    state      <= RESP;
                end
                RESP: if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plus random load/store traffic against a byte-level reference memory model.
module tb_mem_access_unit;
    localparam logic [31:0] START = 32'h01000000;
    localparam int          MEMB  = 1048576;
    localparam logic [31:0] LAST  = START + 32'(MEMB) - 32'd4;

    logic        clk, rst_n, req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err, mem_w_enable;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, resp_rdata, mem_address, mem_data_in, mem_data_out;
    logic [19:0] mi;
    logic [7:0]  mem [MEMB];
    logic [7:0]  exp_mem [MEMB];
    int checks = 0, errors = 0, cyc = 0, wr_cnt = 0, last_wr = -1;
    int acc, snap_wr, exp_lat;
    logic exp_err, exp_wr, t_write;
    logic [2:0] t_f3;
    logic [31:0] t_addr, t_wdata, exp_rdata, snap_addr;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_w_enable(mem_w_enable),
        .mem_data_out(mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing byte memory: combinational 4-byte read, 4-byte write on enabled edges
    assign mi = 20'(mem_address - START);
    assign mem_data_out = {mem[mi + 20'd3], mem[mi + 20'd2], mem[mi + 20'd1], mem[mi]};
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_w_enable) begin
            for (int i = 0; i < 4; i++) mem[mi + 20'(i)] <= mem_data_in[8*i +: 8];
            wr_cnt  <= wr_cnt + 1;
            last_wr <= cyc + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        int o = int'(a - START);
        return {exp_mem[o+3], exp_mem[o+2], exp_mem[o+1], exp_mem[o]};
    endfunction

    function automatic logic [31:0] env_word(input logic [31:0] a);
        int o = int'(a - START);
        return {mem[o+3], mem[o+2], mem[o+1], mem[o]};
    endfunction

    function automatic void set_word(input logic [31:0] a, input logic [31:0] v);
        int o = int'(a - START);
        for (int i = 0; i < 4; i++) begin
            mem[o+i]     = v[8*i +: 8];
            exp_mem[o+i] = v[8*i +: 8];
        end
    endfunction

    function automatic logic is_err(input logic w, input logic [2:0] f3, input logic [31:0] a);
        logic legal = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        logic inr = (a >= START) && (a <= LAST);
        logic mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = (a % (32'd1 << f3[1:0])) != 32'd0;
`endif
        return !legal || !inr || mis;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w = exp_word(a);
        case (f3)
            3'd0:    return 32'(int'(byte'(w[7:0])));
            3'd4:    return 32'(w[7:0]);
            3'd1:    return 32'(int'(shortint'(w[15:0])));
            3'd5:    return 32'(w[15:0]);
            default: return w;
        endcase
    endfunction

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
        t_write = w; t_f3 = f3; t_addr = a; t_wdata = d;
        snap_addr = mem_address; snap_wr = wr_cnt;
        exp_err   = is_err(w, f3, a);
        exp_rdata = (exp_err || w) ? 32'd0 : model_load(f3, a);
        exp_lat   = exp_err ? 1 : (w && f3 != 3'd2) ? 3 : 2;
        exp_wr    = !exp_err && w;
        chk("req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic await_resp(input int hold);
        int n = 1;
        int o = int'(t_addr - START);
        while (resp_valid !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(exp_lat));
        chk("rdata", resp_rdata, exp_rdata);
        chk("err", 32'(resp_err), 32'(exp_err));
        if (exp_wr)
            for (int i = 0; i < (1 << t_f3[1:0]); i++) exp_mem[o+i] = t_wdata[8*i +: 8];
        chk("write_count", 32'(wr_cnt - snap_wr), 32'(exp_wr));
        if (exp_wr) begin
            chk("write_edge", 32'(last_wr), 32'(acc + exp_lat - 1));
            chk("mem_word", env_word(t_addr), exp_word(t_addr));
        end
        if (exp_err) chk("addr_hold", mem_address, snap_addr);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, exp_rdata);
            chk("hold_err", 32'(resp_err), 32'(exp_err));
        end
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d, input int hold);
        issue(w, f3, a, d);
        await_resp(hold);
        release_resp();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        for (int i = 0; i < MEMB; i++) begin
            mem[i] = 8'h00;
            exp_mem[i] = 8'h00;
        end
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'($urandom);
            exp_mem[i] = mem[i];
        end
        set_word(START + 32'h10, 32'h80F17F82);
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_wen", 32'(mem_w_enable), 32'd0);
        chk("rst_addr", mem_address, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        txn(1'b0, 3'd0, START + 32'h10, 32'd0, 0);
        issue(1'b0, 3'd0, START + 32'h10, 32'd0); await_resp(0);
        chk("lb_const", resp_rdata, 32'hFFFFFF82); release_resp();
        issue(1'b0, 3'd4, START + 32'h10, 32'd0); await_resp(0);
        chk("lbu_const", resp_rdata, 32'h00000082); release_resp();
        issue(1'b0, 3'd1, START + 32'h10, 32'd0); await_resp(0);
        chk("lh_const", resp_rdata, 32'h00007F82); release_resp();
        issue(1'b0, 3'd2, START + 32'h10, 32'd0); await_resp(0);
        chk("lw_const", resp_rdata, 32'h80F17F82); release_resp();

        txn(1'b1, 3'd0, START + 32'h10, 32'hAAAAAA55, 0);
        issue(1'b0, 3'd2, START + 32'h10, 32'd0); await_resp(0);
        chk("sb_merge", resp_rdata, 32'h80F17F55); release_resp();

        txn(1'b1, 3'd2, START + 32'h20, 32'hDEADBEEF, 0);
        issue(1'b0, 3'd2, START + 32'h20, 32'd0); await_resp(0);
        chk("sw_lw", resp_rdata, 32'hDEADBEEF); release_resp();

        issue(1'b0, 3'd2, 32'h00FFFFFC, 32'd0); await_resp(0);
        chk("low_err", 32'(resp_err), 32'd1); release_resp();
        issue(1'b0, 3'd2, 32'h010FFFFD, 32'd0); await_resp(0);
        chk("high_err", 32'(resp_err), 32'd1); release_resp();
        txn(1'b0, 3'd2, LAST, 32'd0, 0);
        issue(1'b0, 3'd3, START + 32'h10, 32'd0); await_resp(0);
        chk("f3_011_err", 32'(resp_err), 32'd1); release_resp();
        issue(1'b1, 3'd4, START + 32'h10, 32'h12345678); await_resp(0);
        chk("sbu_err", 32'(resp_err), 32'd1); release_resp();

        txn(1'b0, 3'd2, START + 32'h2, 32'd0, 0);
        txn(1'b1, 3'd1, START + 32'h41, 32'hCAFEF00D, 0);
        txn(1'b0, 3'd2, START + 32'h40, 32'd0, 5);

        // Response handshake and a new request in the same cycle: the request waits for IDLE
        issue(1'b0, 3'd2, START + 32'h20, 32'd0);
        await_resp(0);
        req_write = 1'b0; req_funct3 = 3'd5; req_addr = START + 32'h12; req_valid = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("b2b_no_accept", 32'(req_ready), 32'd1);
        txn(1'b0, 3'd5, START + 32'h12, 32'd0, 0);

        issue(1'b1, 3'd1, START + 32'h30, 32'h12345678);
        @(negedge clk);
        chk("rmw_wr_wen", 32'(mem_w_enable), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_gate_wen", 32'(mem_w_enable), 32'd0);
        @(negedge clk);
        chk("rst_mid_ready", 32'(req_ready), 32'd0);
        chk("rst_mid_valid", 32'(resp_valid), 32'd0);
        chk("rst_mid_din", mem_data_in, 32'd0);
        chk("rst_mid_addr", mem_address, 32'd0);
        @(negedge clk);
        chk("rst_hold_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", 32'(req_ready), 32'd1);
        chk("rst_no_write", 32'(wr_cnt - snap_wr), 32'd0);
        chk("rst_word_kept", env_word(START + 32'h30), exp_word(START + 32'h30));

        for (int k = 0; k < 80; k++) begin
            int r;
            logic [31:0] a;
            r = int'($urandom_range(0, 9));
            a = (r == 0) ? LAST - 32'd2 + 32'($urandom_range(0, 5)) :
                (r == 1) ? START - 32'd2 + 32'($urandom_range(0, 3)) :
                           START + 32'($urandom_range(0, 127));
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, int'($urandom_range(0, 2)));
        end
        for (int k = 0; k < 16; k++) txn(1'b0, 3'd2, START + 32'(4 * k), 32'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator sitting between the CPU execute/memory stage and the byte-addressed `memory` block. It accepts one RISC-V load or store per handshake and drives `memory`'s address/data_in/w_enable port. It sign- or zero-extends load data and implements SB/SH as read-modify-write, because `memory` always writes four bytes starting at `address`. It returns a registered response with an error flag.

## Interface
Parameters:
- START_ADDR, 32'h01000000, lowest legal byte address
- MEM_BYTES, 1048576, size of the backing memory in bytes

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low bytes are used for B/H
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  illegal funct3 / out-of-range / misaligned (macro)
- mem_address  out  32  to memory address
- mem_data_in  out  32  to memory data_in
- mem_w_enable  out  1  to memory w_enable
- mem_data_out  in  32  from memory data_out; combinational read of mem_address..+3

## Operation
- States: IDLE, ACCESS, RMW_RD, RMW_WR, RESP.
- IDLE: req_ready=1. On req_valid, latch write, funct3, addr and wdata, then decode:
  - error → RESP with err=1
  - load or SW → ACCESS
  - SB/SH → RMW_RD
- Error conditions:
  - funct3 ∈ {011,110,111}, or store with funct3 100/101
  - addr < START_ADDR or addr > START_ADDR+MEM_BYTES-4
  - misalignment, only when the macro is enabled
- Errored requests never assert mem_w_enable and never change mem_address.
- ACCESS, load: mem_address=addr, mem_w_enable=0. Capture mem_data_out into resp_rdata:
  - B: sign-extend [7:0]
  - BU: zero-extend [7:0]
  - H: sign-extend [15:0]
  - HU: zero-extend [15:0]
  - W: full 32 bits
  - Next state RESP.
- ACCESS, SW: mem_address=addr, mem_data_in=wdata, mem_w_enable=1 → RESP.
- RMW_RD: mem_address=addr, w_enable=0. Capture mem_data_out as old → RMW_WR.
- RMW_WR: mem_address=addr, mem_w_enable=1, data_in as follows → RESP.
  - SB: {old[31:8], wdata[7:0]}
  - SH: {old[31:16], wdata[15:0]}
- RESP: resp_valid=1. Hold resp_rdata and resp_err until resp_ready, then → IDLE.
- mem_address holds its last value outside access states, so memory's read path does not toggle.
- mem_w_enable is high only in ACCESS (store) and RMW_WR, gated by rst_n.

## Timing
- Request accepted at edge N (IDLE, valid):
  - load/SW: ACCESS in cycle N+1, resp_valid from N+2
  - SB/SH: RMW_RD N+1, RMW_WR N+2, resp_valid from N+3
  - error: resp_valid from N+1
- Memory write commits at the edge ending ACCESS or RMW_WR.
- Throughput: one outstanding request. With resp_ready tied high, the next accept happens at the cycle after RESP.
- Reset: while rst_n=0 at an edge, state←IDLE and resp_rdata, resp_err, old and mem_address←0.
  - While rst_n is low: req_ready=0, resp_valid=0, mem_w_enable=0, mem_data_in=0.
  - Reset during RMW_WR or store ACCESS suppresses that write; memory is unchanged.
- req_valid in a non-IDLE state is ignored, and the request is not latched.
- resp_valid and resp_ready high in the same cycle as a new req_valid: no accept that cycle; accept occurs in IDLE next cycle.

## Configuration
- MISALIGN_TRAP_EN defined: H/HU/SH with addr[0]≠0, or W/SW with addr[1:0]≠0, responds with err=1 and no memory access.
- MISALIGN_TRAP_EN undefined: misaligned accesses proceed unchanged. Memory is byte-addressed, so they complete normally with the same latency.

## Test plan
- Memory word at 0x01000010 = 0x80F1_7F82. LB @0x01000010 → resp_rdata 0xFFFFFF82 at N+2. LBU → 0x00000082. LH → 0x00007F82. LW → 0x80F17F82.
- SB wdata 0xAAAA_AA55 @0x01000010 over 0x80F17F82 → mem_w_enable only in cycle N+2, data_in 0x80F17F55. Follow-up LW returns 0x80F17F55; resp_valid at N+3.
- SW 0xDEADBEEF @0x01000020, then LW → 0xDEADBEEF, err=0. Loads @0x00FFFFFC and @0x010FFFFD → err=1, rdata 0, mem_w_enable never high.
- funct3=011 load and funct3=100 store → err=1 at N+1, no write observed.
- LW @0x01000002: with MISALIGN_TRAP_EN → err=1; without → bytes 0x01000002..05 assembled little-endian, err=0.
- Assert rst_n=0 during RMW_WR of SH → target word unchanged, req_ready=0 while reset is held, IDLE with req_ready=1 one cycle after release. Also hold resp_ready=0 for 5 cycles → resp_valid, rdata and err stable throughout.
